bp_table_ctrl: RTL

Write-port controller for the gshare predictor tables (BTB, PHT, GHR). It buffers commit-stage update requests in a small FIFO and issues them to the table write ports at most one per cycle. It also runs a multi-cycle table clear sequence after reset and on flush requests, such as fence.i or a context switch. It gates fetch-side predictions until the tables are valid, and sits between the commit stage and the predictor tables.

---
 rtl/bp_table_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bp_table_ctrl.sv
// Write-port controller for the gshare BTB/PHT/GHR: queues commit-stage updates,
// issues at most one table write per cycle, and sequences full-table clears.
module bp_table_ctrl #(
    parameter int INDEX_WIDTH   = 6,
    parameter int HISTORY_WIDTH = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        upd_valid_i,
    input  logic                        upd_btb_wr_i,
    input  logic [INDEX_WIDTH-1:0]      upd_btb_index_i,
    input  logic [32-INDEX_WIDTH-2-1:0] upd_btb_tag_i,
    input  logic [31:0]                 upd_btb_target_i,
    input  logic [HISTORY_WIDTH-1:0]    upd_pht_index_i,
    input  logic                        upd_taken_i,
    output logic                        upd_ready_o,
    output logic                        upd_drop_o,
    input  logic                        flush_req_i,
    output logic                        flush_busy_o,
    input  logic                        tbl_stall_i,
    output logic                        btb_wren_o,
    output logic [INDEX_WIDTH-1:0]      btb_wr_index_o,
    output logic [32-INDEX_WIDTH-2-1:0] btb_wr_tag_o,
    output logic [31:0]                 btb_wr_target_o,
    output logic                        btb_wr_valid_o,
    output logic                        pht_wren_o,
    output logic [HISTORY_WIDTH-1:0]    pht_wr_index_o,
    output logic                        pht_taken_o,
    output logic                        pht_init_o,
    output logic                        ghr_clear_o,
    output logic                        pred_en_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int TAG_WIDTH   = 32 - INDEX_WIDTH - 2;
    localparam int CW          = (INDEX_WIDTH > HISTORY_WIDTH) ? INDEX_WIDTH : HISTORY_WIDTH;
    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PW + 1;
    localparam int BTB_ENTRIES = 1 << INDEX_WIDTH;
    localparam int PHT_ENTRIES = 1 << HISTORY_WIDTH;

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     clr_idx_reg, clr_idx_next;
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic                     fifo_btb_wr     [FIFO_DEPTH];
    logic [INDEX_WIDTH-1:0]   fifo_btb_index  [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]     fifo_btb_tag    [FIFO_DEPTH];
    logic [31:0]              fifo_btb_target [FIFO_DEPTH];
    logic [HISTORY_WIDTH-1:0] fifo_pht_index  [FIFO_DEPTH];
    logic                     fifo_taken      [FIFO_DEPTH];

    logic issue, push, pop, clearing, clr_btb, clr_pht;

    // Reset also blocks issue so nothing from the old state leaks out during the reset cycle.
    assign issue    = !tbl_stall_i && !rst_i;
    assign clearing = (state_reg == ST_CLEAR);
    assign clr_btb  = int'(clr_idx_reg) < BTB_ENTRIES;
    assign clr_pht  = int'(clr_idx_reg) < PHT_ENTRIES;

    assign upd_ready_o  = (state_reg == ST_RUN) && (count_reg < CNT_W'(FIFO_DEPTH)) && !rst_i;
    assign upd_drop_o   = upd_valid_i && !upd_ready_o;
    assign push         = upd_valid_i && upd_ready_o;
    assign pop          = issue && !clearing && (count_reg != '0);
    assign pred_en_o    = (state_reg == ST_RUN);
    assign flush_busy_o = (state_reg != ST_RUN);
    assign ghr_clear_o  = clearing && (clr_idx_reg == '0);
    assign fifo_count_o = count_reg;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk_i) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    fifo_btb_wr[gi]     <= upd_btb_wr_i;
                    fifo_btb_index[gi]  <= upd_btb_index_i;
                    fifo_btb_tag[gi]    <= upd_btb_tag_i;
                    fifo_btb_target[gi] <= upd_btb_target_i;
                    fifo_pht_index[gi]  <= upd_pht_index_i;
                    fifo_taken[gi]      <= upd_taken_i;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Write-port mux: clear sweep in CLEAR, FIFO head otherwise; idle fields read as 0.
    always_comb begin
        btb_wren_o      = 1'b0;
        btb_wr_index_o  = '0;
        btb_wr_tag_o    = '0;
        btb_wr_target_o = '0;
        btb_wr_valid_o  = 1'b0;
        pht_wren_o      = 1'b0;
        pht_wr_index_o  = '0;
        pht_taken_o     = 1'b0;
        pht_init_o      = 1'b0;
        if (clearing && issue) begin
            if (clr_btb) begin
                btb_wren_o     = 1'b1;
                btb_wr_index_o = clr_idx_reg[INDEX_WIDTH-1:0];
            end
            if (clr_pht) begin
                pht_wren_o     = 1'b1;
                pht_init_o     = 1'b1;
                pht_wr_index_o = clr_idx_reg[HISTORY_WIDTH-1:0];
            end
        end else if (pop) begin
            pht_wren_o     = 1'b1;
            pht_wr_index_o = fifo_pht_index[rd_ptr_reg];
            pht_taken_o    = fifo_taken[rd_ptr_reg];
            if (fifo_btb_wr[rd_ptr_reg]) begin
                btb_wren_o      = 1'b1;
                btb_wr_valid_o  = 1'b1;
                btb_wr_index_o  = fifo_btb_index[rd_ptr_reg];
                btb_wr_tag_o    = fifo_btb_tag[rd_ptr_reg];
                btb_wr_target_o = fifo_btb_target[rd_ptr_reg];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (flush_req_i) begin
                    clr_idx_next = '0;
                end else if (issue) begin
                    if (&clr_idx_reg) begin
                        state_next   = ST_RUN;
                        clr_idx_next = '0;
                    end else begin
                        clr_idx_next = clr_idx_reg + CW'(1);
                    end
                end
            end
            ST_RUN: begin
                // Decide on post-cycle occupancy so an update accepted alongside the flush still drains.
                if (flush_req_i) begin
                    state_next   = (count_next == '0) ? ST_CLEAR : ST_DRAIN;
                    clr_idx_next = '0;
                end
            end
            ST_DRAIN: begin
                if (pop && (count_reg == CNT_W'(1))) begin
                    state_next   = ST_CLEAR;
                    clr_idx_next = '0;
                end
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_CLEAR;
            clr_idx_reg <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
            count_reg   <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

endmodule
